soc_wb2sram_bridge: RTL and testbench

Wishbone B3 slave that converts bus cycles into the single-port SRAM control interface (chip enable, write enable, output enable, word address, byte selects, write data) and returns read data from the SRAM's one-cycle registered output. It sits directly upstream of the single-port SRAM macro in every tile memory and in the shared memory subsystem. It handles classic single cycles, incrementing read bursts with linear or wrapping address sequences, and address range checking.

---
 rtl/soc_wb2sram_bridge.sv | 168 ++++++++++++++++
 tb/tb_soc_wb2sram_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_wb2sram_bridge.sv
// Wishbone B3 slave driving a single-port SRAM whose read data is registered one cycle after the address.
// Define SOC_WB2SRAM_BURST_EN to compile in incrementing read bursts (BURST state, cti/bte decoding).
module soc_wb2sram_bridge #(
    parameter int unsigned AW            = 32,
    parameter int unsigned DW            = 32,
    parameter int unsigned WORD_AW       = AW - ((DW / 8) >> 1),
    parameter int unsigned MEM_SIZE_BYTE = 32768
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [AW-1:0]      wb_adr_i,
    input  logic [DW-1:0]      wb_dat_i,
    input  logic [DW/8-1:0]    wb_sel_i,
    input  logic               wb_we_i,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic [2:0]         wb_cti_i,
    input  logic [1:0]         wb_bte_i,
    output logic [DW-1:0]      wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               wb_rty_o,
    output logic               sram_ce,
    output logic               sram_we,
    output logic               sram_oe,
    output logic [WORD_AW-1:0] sram_waddr,
    output logic [DW-1:0]      sram_din,
    output logic [DW/8-1:0]    sram_sel,
    input  logic [DW-1:0]      sram_dout
);

    localparam int unsigned SW        = DW / 8;
    localparam int unsigned OFS       = SW >> 1;
    localparam int unsigned MEM_WORDS = MEM_SIZE_BYTE / SW;
    localparam logic [2:0]  CTI_INC   = 3'b010;

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state_q, state_d;
    logic               ack_d, err_d;
    logic               ce_c, we_c, oe_c;
    logic [WORD_AW-1:0] waddr_c;
    logic [WORD_AW-1:0] req_addr;
    logic               req;
    logic               unused_c;

    function automatic logic in_range(input logic [WORD_AW-1:0] a);
        return 64'(a) < 64'(MEM_WORDS);
    endfunction

`ifdef SOC_WB2SRAM_BURST_EN
    logic [WORD_AW-1:0] burst_addr_q, burst_addr_d;
    logic [WORD_AW-1:0] last_addr_q, last_addr_d;

    // Wrapping bursts only advance the low bits selected by the mask; linear uses all bits.
    function automatic logic [WORD_AW-1:0] next_addr(input logic [WORD_AW-1:0] a,
                                                     input logic [1:0] bte);
        logic [WORD_AW-1:0] inc;
        logic [WORD_AW-1:0] mask;
        inc = a + WORD_AW'(1);
        case (bte)
            2'b01:   mask = WORD_AW'(3);
            2'b10:   mask = WORD_AW'(7);
            2'b11:   mask = WORD_AW'(15);
            default: mask = '1;
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction
`endif

    assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
    assign req_addr = wb_adr_i[OFS +: WORD_AW];
    assign unused_c = ^{wb_adr_i, wb_cti_i, wb_bte_i};

    // Next state, terminations and SRAM strobes
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        ce_c    = 1'b0;
        we_c    = 1'b0;
        oe_c    = 1'b0;
        waddr_c = req_addr;
`ifdef SOC_WB2SRAM_BURST_EN
        burst_addr_d = burst_addr_q;
        last_addr_d  = last_addr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (in_range(req_addr)) begin
                        ce_c  = 1'b1;
                        we_c  = wb_we_i;
                        oe_c  = ~wb_we_i;
                        ack_d = 1'b1;
`ifdef SOC_WB2SRAM_BURST_EN
                        if (!wb_we_i && wb_cti_i == CTI_INC) begin
                            state_d      = BURST;
                            burst_addr_d = next_addr(req_addr, wb_bte_i);
                            last_addr_d  = req_addr;
                        end
`endif
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
`ifdef SOC_WB2SRAM_BURST_EN
            BURST: begin
                waddr_c = burst_addr_q;
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (!wb_stb_i) begin
                    // The prefetch issued last cycle was never consumed; re-read it on resume.
                    if (wb_ack_o) burst_addr_d = last_addr_q;
                end else if (wb_ack_o && wb_cti_i != CTI_INC) begin
                    state_d = IDLE;
                end else if (!in_range(burst_addr_q)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    ce_c         = 1'b1;
                    oe_c         = 1'b1;
                    ack_d        = 1'b1;
                    burst_addr_d = next_addr(burst_addr_q, wb_bte_i);
                    last_addr_d  = burst_addr_q;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_ack_o <= ack_d;
            wb_err_o <= err_d;
        end
    end

`ifdef SOC_WB2SRAM_BURST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            burst_addr_q <= '0;
            last_addr_q  <= '0;
        end else begin
            burst_addr_q <= burst_addr_d;
            last_addr_q  <= last_addr_d;
        end
    end
`endif

    // Strobes are gated by reset so an access in flight stops the instant reset asserts.
    assign sram_ce    = rst & ce_c;
    assign sram_we    = rst & we_c;
    assign sram_oe    = rst & oe_c;
    assign sram_waddr = waddr_c;
    assign sram_din   = wb_dat_i;
    assign sram_sel   = wb_sel_i;
    assign wb_dat_o   = sram_dout;
    assign wb_rty_o   = 1'b0;

endmodule

// File: tb/tb_soc_wb2sram_bridge.sv
// Scoreboard bench for soc_wb2sram_bridge: a Wishbone master queues expected terminations,
// a negedge monitor pops and compares them; a behavioural SRAM with registered read data.
module tb_soc_wb2sram_bridge;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;
    localparam int unsigned SW      = 4;
    localparam int unsigned WORD_AW = 30;
    localparam int unsigned MEM     = 1024;
`ifdef SOC_WB2SRAM_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef struct packed {
        logic        is_err;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [AW-1:0]      wb_adr_i;
    logic [DW-1:0]      wb_dat_i;
    logic [SW-1:0]      wb_sel_i;
    logic               wb_we_i, wb_cyc_i, wb_stb_i;
    logic [2:0]         wb_cti_i;
    logic [1:0]         wb_bte_i;
    logic [DW-1:0]      wb_dat_o;
    logic               wb_ack_o, wb_err_o, wb_rty_o;
    logic               sram_ce, sram_we, sram_oe;
    logic [WORD_AW-1:0] sram_waddr;
    logic [DW-1:0]      sram_din;
    logic [SW-1:0]      sram_sel;
    logic [DW-1:0]      sram_dout;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   we_cnt   = 0;
    int   ce_cnt   = 0;
    int   err_cnt  = 0;
    logic mon_en;
    logic post_ack;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] b_adr [8];
    logic [31:0] b_dat [8];
    logic [3:0]  b_sel [8];
    logic [2:0]  b_cti [8];
    logic [31:0] b_exp [8];
    logic        b_err [8];

    logic [31:0] mem [256];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_dat;

    always #5 clk = ~clk;

    soc_wb2sram_bridge #(
        .AW(AW), .DW(DW), .WORD_AW(WORD_AW), .MEM_SIZE_BYTE(MEM)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe), .sram_waddr(sram_waddr),
        .sram_din(sram_din), .sram_sel(sram_sel), .sram_dout(sram_dout)
    );

    // SRAM macro model: byte-masked write, registered read
    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_idx] <= pl_dat;
        end else if (sram_ce) begin
            if (sram_we)
                for (int b = 0; b < 4; b++)
                    if (sram_sel[b]) mem[sram_waddr[7:0]][8*b +: 8] <= sram_din[8*b +: 8];
            if (sram_oe) sram_dout <= mem[sram_waddr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every real termination (stb high) is matched against the scoreboard head
    always @(negedge clk) begin
        if (sram_we) we_cnt++;
        if (sram_ce) ce_cnt++;
        if (wb_err_o) err_cnt++;
        if (mon_en && wb_cyc_i && wb_stb_i && (wb_ack_o || wb_err_o)) begin
            chk("ack_err_exclusive", 32'(wb_ack_o & wb_err_o), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_term: ack=%0b err=%0b with empty scoreboard (t=%0t)",
                         wb_ack_o, wb_err_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("term_is_err", 32'(wb_err_o), 32'(mon_e.is_err));
                if (mon_e.chk_data) chk("read_data", wb_dat_o, mon_e.data);
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] d);
        pl_en  = 1'b1;
        pl_idx = 8'(idx);
        pl_dat = d;
        @(posedge clk); #1;
        pl_en  = 1'b0;
    endtask

    task automatic set_beat(input int i, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [2:0] cti,
                            input logic [31:0] expd, input logic err);
        b_adr[i] = adr; b_dat[i] = dat; b_sel[i] = sel;
        b_cti[i] = cti; b_exp[i] = expd; b_err[i] = err;
    endtask

    task automatic drive(input int i, input logic we, input logic [1:0] bte);
        exp_t e;
        wb_adr_i = b_adr[i]; wb_dat_i = b_dat[i]; wb_sel_i = b_sel[i];
        wb_cti_i = b_cti[i]; wb_we_i = we; wb_bte_i = bte;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        e.is_err   = b_err[i];
        e.chk_data = ~we & ~b_err[i];
        e.data     = b_exp[i];
        exp_q.push_back(e);
    endtask

    // Master: advances one beat per sampled termination; optional stb wait after beat wait_at
    task automatic run(input int n, input logic we, input logic [1:0] bte,
                       input int wait_at, input int wait_len, output int cycles);
        int   i;
        logic term, was_err;
        i = 0;
        cycles = 0;
        drive(0, we, bte);
        while (i < n) begin
            @(negedge clk);
            cycles++;
            term    = wb_ack_o | wb_err_o;
            was_err = wb_err_o;
            @(posedge clk); #1;
            if (term) begin
                i++;
                if (was_err || i >= n) break;
                if (i == wait_at) begin
                    wb_stb_i = 1'b0;
                    repeat (wait_len) @(posedge clk);
                    #1;
                end
                drive(i, we, bte);
            end else if (cycles > 64) begin
                chk("run_timeout", 32'(cycles), 32'd0);
                break;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
        @(negedge clk);
        post_ack = wb_ack_o;
        @(posedge clk); #1;
    endtask

    function automatic int exp_cycles(input int beats);
        return BURST_EN ? beats + 1 : 2 * beats;
    endfunction

    initial begin
        int cyc_n;
        int we0, ce0, er0;
        rst = 1'b1; mon_en = 1'b1; pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = '0; wb_bte_i = '0;
        #1 rst = 1'b0;
        #17;
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_err", 32'(wb_err_o), 32'd0);
        chk("rst_rty", 32'(wb_rty_o), 32'd0);
        chk("rst_ce",  32'(sram_ce),  32'd0);
        chk("rst_we",  32'(sram_we),  32'd0);
        chk("rst_oe",  32'(sram_oe),  32'd0);
        #5 rst = 1'b1;
        @(posedge clk); #1;

        // Classic write, byte-masked write, read back
        we0 = we_cnt;
        set_beat(0, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0, 1'b0);
        run(1, 1'b1, 2'b00, -1, 0, cyc_n);
        chk("classic_wr1_cycles", 32'(cyc_n), 32'd2);
        set_beat(0, 32'h10, 32'h000000AA, 4'h1, 3'b000, 32'h0, 1'b0);
        run(1, 1'b1, 2'b00, -1, 0, cyc_n);
        chk("classic_wr2_cycles", 32'(cyc_n), 32'd2);
        set_beat(0, 32'h10, 32'h0, 4'hF, 3'b000, 32'hDEADBEAA, 1'b0);
        run(1, 1'b0, 2'b00, -1, 0, cyc_n);
        chk("classic_rd_cycles", 32'(cyc_n), 32'd2);
        chk("classic_ack_clears", 32'(post_ack), 32'd0);
        chk("classic_we_cycles", 32'(we_cnt - we0), 32'd2);

        // Linear read burst of 4 from 0x20
        for (int k = 0; k < 4; k++) preload(8 + k, 32'(k + 1));
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h20 + 32'(4 * k), 32'h0, 4'hF, (k == 3) ? 3'b111 : 3'b010,
                     32'(k + 1), 1'b0);
        run(4, 1'b0, 2'b00, -1, 0, cyc_n);
        chk("linear_cycles", 32'(cyc_n), 32'(exp_cycles(4)));
        chk("linear_ack_clears", 32'(post_ack), 32'd0);

        // Wrap4 burst from word 14: 14, 15, 12, 13
        preload(12, 32'hC0); preload(13, 32'hD0); preload(14, 32'hE0); preload(15, 32'hF0);
        set_beat(0, 32'h38, 32'h0, 4'hF, 3'b010, 32'hE0, 1'b0);
        set_beat(1, 32'h3C, 32'h0, 4'hF, 3'b010, 32'hF0, 1'b0);
        set_beat(2, 32'h30, 32'h0, 4'hF, 3'b010, 32'hC0, 1'b0);
        set_beat(3, 32'h34, 32'h0, 4'hF, 3'b111, 32'hD0, 1'b0);
        run(4, 1'b0, 2'b01, -1, 0, cyc_n);
        chk("wrap4_cycles", 32'(cyc_n), 32'(exp_cycles(4)));

        // Out-of-range classic read
        ce0 = ce_cnt; er0 = err_cnt;
        set_beat(0, 32'h400, 32'h0, 4'hF, 3'b000, 32'h0, 1'b1);
        run(1, 1'b0, 2'b00, -1, 0, cyc_n);
        chk("oor_cycles", 32'(cyc_n), 32'd2);
        chk("oor_no_ce", 32'(ce_cnt - ce0), 32'd0);
        chk("oor_err_one_cycle", 32'(err_cnt - er0), 32'd1);

        // Burst crossing the end of memory: third beat errors, no strobe for it
        preload(254, 32'hFE); preload(255, 32'hFF);
        ce0 = ce_cnt; er0 = err_cnt;
        set_beat(0, 32'h3F8, 32'h0, 4'hF, 3'b010, 32'hFE, 1'b0);
        set_beat(1, 32'h3FC, 32'h0, 4'hF, 3'b010, 32'hFF, 1'b0);
        set_beat(2, 32'h400, 32'h0, 4'hF, 3'b111, 32'h0,  1'b1);
        run(3, 1'b0, 2'b00, -1, 0, cyc_n);
        chk("cross_cycles", 32'(cyc_n), 32'(exp_cycles(3)));
        chk("cross_ce_count", 32'(ce_cnt - ce0), 32'd2);
        chk("cross_err_one_cycle", 32'(err_cnt - er0), 32'd1);

        // Wait state: stb low for 2 cycles after beat 2
        for (int k = 0; k < 4; k++)
            set_beat(k, 32'h20 + 32'(4 * k), 32'h0, 4'hF, (k == 3) ? 3'b111 : 3'b010,
                     32'(k + 1), 1'b0);
        run(4, 1'b0, 2'b00, 2, 2, cyc_n);
        chk("wait_sb_drained", 32'(exp_q.size()), 32'd0);
        chk("wait_ack_clears", 32'(post_ack), 32'd0);

        // Reset asserted mid-burst
        mon_en = 1'b0;
        wb_adr_i = 32'h20; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cti_i = 3'b010;
        wb_bte_i = 2'b00; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_async_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_async_ce",  32'(sram_ce),  32'd0);
        chk("rst_async_err", 32'(wb_err_o), 32'd0);
        ce0 = ce_cnt;
        repeat (3) @(negedge clk);
        chk("rst_no_sram_access", 32'(ce_cnt - ce0), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_cti_i = 3'b000;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        set_beat(0, 32'h10, 32'h0, 4'hF, 3'b000, 32'hDEADBEAA, 1'b0);
        run(1, 1'b0, 2'b00, -1, 0, cyc_n);
        chk("post_rst_rd_cycles", 32'(cyc_n), 32'd2);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
